// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin share of one carry_mult among NUM_REQ requesters, registered tagged result.
// Define MULT_ARB_PIPE_EN to add an operand register stage ahead of the multiplier (latency 2).

module carry_mult #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    assign p = a * b;
endmodule

module mult_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]          res_id
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, grant, res_id_q, res_id_d, mul_id;
    logic [2*WIDTH-1:0]   res_data_q, res_data_d, prod;
    logic [WIDTH-1:0]     sel_a, sel_b, mul_a, mul_b;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        cand;
    logic                 any, out_free, stage_free, accept, load;
`ifdef MULT_ARB_PIPE_EN
    logic                 op_valid_q, op_valid_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ID_W-1:0]      op_id_q, op_id_d;
`endif

    carry_mult #(.WIDTH(WIDTH)) u_mult (.a(mul_a), .b(mul_b), .p(prod));

    always_comb begin
        // rotate so bit 0 is the requester at rr_ptr; lowest set bit wins
        rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        grant = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (rot[k]) grant = cand[ID_W-1:0];
        end
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
        any = |req_valid;
        res_valid = (state_q == FULL);
        out_free = !res_valid || res_ready;
`ifdef MULT_ARB_PIPE_EN
        stage_free = !op_valid_q || out_free;
        accept = any && stage_free;
        op_valid_d = stage_free ? accept : op_valid_q;
        op_a_d = accept ? sel_a : op_a_q;
        op_b_d = accept ? sel_b : op_b_q;
        op_id_d = accept ? grant : op_id_q;
        mul_a = op_a_q;
        mul_b = op_b_q;
        mul_id = op_id_q;
        load = op_valid_q && out_free;
`else
        stage_free = out_free;
        accept = any && stage_free;
        mul_a = sel_a;
        mul_b = sel_b;
        mul_id = grant;
        load = accept;
`endif
        req_ready = NUM_REQ'(accept) << grant;
        rr_ptr_d = accept ? ((grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1)) : rr_ptr_q;
        state_d = load ? FULL : (res_ready ? EMPTY : state_q);
        res_data_d = load ? prod : res_data_q;
        res_id_d = load ? mul_id : res_id_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            rr_ptr_q <= '0;
            res_data_q <= '0;
            res_id_q <= '0;
`ifdef MULT_ARB_PIPE_EN
            op_valid_q <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            op_id_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            res_data_q <= res_data_d;
            res_id_q <= res_id_d;
`ifdef MULT_ARB_PIPE_EN
            op_valid_q <= op_valid_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            op_id_q <= op_id_d;
`endif
        end
    end

    assign res_data = res_data_q;
    assign res_id = res_id_q;
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: fixed vector table, handshake corner sequences and random traffic
// against a transaction-level model of the arbiter (default single-stage build).

module tb_mult_rr_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_id;

    always #5 clk = ~clk;

    mult_rr_arbiter #(.WIDTH(8), .NUM_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int d;
        int id;
    } ent_t;

    ent_t q[$];
    ent_t last;
    int   rr;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
        logic [3:0]  rdy;
        logic        rv;
        logic [15:0] d;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0;
        last.d = 0;
        last.id = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_id", 32'(res_id), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // one clock: predict from the model, compare mid-cycle, then advance the model at the edge
    task automatic cycle(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic r, output logic [3:0] er);
        int   g;
        bit   acc;
        ent_t e;
        int   pa, pb;
        req_valid = v;
        req_a = a;
        req_b = b;
        res_ready = r;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            if (g < 0 && v[2'(i)]) g = i;
        end
        acc = (g >= 0) && (q.size() == 0 || r);
        er = acc ? 4'(1 << g) : 4'b0;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("res_valid", 32'(res_valid), (q.size() > 0) ? 1 : 0);
        e = (q.size() > 0) ? q[0] : last;
        chk("res_data", 32'(res_data), e.d);
        chk("res_id", 32'(res_id), e.id);
        @(posedge clk);
        if (q.size() > 0 && r) last = q.pop_front();
        if (acc) begin
            pa = int'((a >> (8 * g)) & 32'hFF);
            pb = int'((b >> (8 * g)) & 32'hFF);
            q.push_back('{pa * pb, g});
            rr = (g + 1) % N;
        end
        #1;
    endtask

    function automatic logic [7:0] rand_op();
        int s;
        s = $urandom_range(5);
        return s == 0 ? 8'h00 : s == 1 ? 8'hFF : 8'($urandom);
    endfunction

    initial begin
        logic [3:0]  v, er;
        logic [31:0] a, b;
        tbl[0]  = '{4'b0001, 32'h0000000C, 32'h0000000A, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0};
        tbl[1]  = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 16'h0078, 2'd0};
        tbl[2]  = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 16'h0078, 2'd0};
        tbl[3]  = '{4'b1111, 32'h04030201, 32'h40302010, 1'b1, 4'b0010, 1'b0, 16'h0078, 2'd0};
        tbl[4]  = '{4'b1111, 32'h04030201, 32'h40302010, 1'b1, 4'b0100, 1'b1, 16'h0040, 2'd1};
        tbl[5]  = '{4'b1111, 32'h04030201, 32'h40302010, 1'b1, 4'b1000, 1'b1, 16'h0090, 2'd2};
        tbl[6]  = '{4'b1111, 32'h04030201, 32'h40302010, 1'b1, 4'b0001, 1'b1, 16'h0100, 2'd3};
        tbl[7]  = '{4'b1111, 32'h04030201, 32'h40302010, 1'b1, 4'b0010, 1'b1, 16'h0010, 2'd0};
        tbl[8]  = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 1'b1, 4'b0100, 1'b1, 16'h0040, 2'd1};
        tbl[9]  = '{4'b0001, 32'h00000000, 32'h000000FF, 1'b1, 4'b0001, 1'b1, 16'hFE01, 2'd2};
        tbl[10] = '{4'b1000, 32'h80000000, 32'h02000000, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd0};
        tbl[11] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 16'h0100, 2'd3};
        tbl[12] = '{4'b0100, 32'h00050000, 32'h00070000, 1'b1, 4'b0100, 1'b0, 16'h0100, 2'd3};
        tbl[13] = '{4'b0110, 32'h00050600, 32'h00070900, 1'b1, 4'b0010, 1'b1, 16'h0023, 2'd2};
        tbl[14] = '{4'b0110, 32'h00050600, 32'h00070900, 1'b1, 4'b0100, 1'b1, 16'h0036, 2'd1};
        tbl[15] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 16'h0023, 2'd2};

        reset_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        for (int n = 0; n < 16; n++) begin
            req_valid = tbl[n].v;
            req_a = tbl[n].a;
            req_b = tbl[n].b;
            res_ready = tbl[n].r;
            @(negedge clk);
            chk($sformatf("row%0d_ready", n), 32'(req_ready), 32'(tbl[n].rdy));
            chk($sformatf("row%0d_valid", n), 32'(res_valid), 32'(tbl[n].rv));
            chk($sformatf("row%0d_data", n), 32'(res_data), 32'(tbl[n].d));
            chk($sformatf("row%0d_id", n), 32'(res_id), 32'(tbl[n].id));
            @(posedge clk);
            #1;
        end

        // back-pressure: result held three cycles, then same-cycle accept on release
        do_reset();
        cycle(4'b1111, 32'h0D0C0B0A, 32'h11223344, 1'b1, er);
        repeat (3) cycle(4'b1111, 32'h0D0C0B0A, 32'h11223344, 1'b0, er);
        repeat (3) cycle(4'b1111, 32'h0D0C0B0A, 32'h11223344, 1'b1, er);
        repeat (2) cycle(4'b0000, 32'h0, 32'h0, 1'b1, er);

        // reset while a result is pending, then pointer restarts at 0
        cycle(4'b0010, 32'h00000700, 32'h00000300, 1'b0, er);
        chk("pre_rst_valid", 32'(res_valid), 1);
        do_reset();
        cycle(4'b1000, 32'h09000000, 32'h09000000, 1'b1, er);
        cycle(4'b0000, 32'h0, 32'h0, 1'b1, er);

        do_reset();
        v = '0;
        a = '0;
        b = '0;
        er = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[2'(i)] || er[2'(i)]) begin
                    v[2'(i)] = ($urandom_range(9) < 6);
                    a[8*i +: 8] = rand_op();
                    b[8*i +: 8] = rand_op();
                end
            end
            cycle(v, a, b, ($urandom_range(3) != 0), er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
